// File: rtl/gshare_pred_table_pkg.sv
// Shared definitions for the gshare/bimodal direction predictor:
// counter encodings, FSM states and the saturating-counter step.
package gshare_pred_table_pkg;

    // Two-bit counter encodings (strongly/weakly not-taken, weakly/strongly taken).
    localparam logic [1:0] CNT_SNT = 2'd0;
    localparam logic [1:0] CNT_WNT = 2'd1;
    localparam logic [1:0] CNT_WT  = 2'd2;
    localparam logic [1:0] CNT_ST  = 2'd3;

    // Widest counter the shared step function handles.
    localparam int SAT_MAX_W = 8;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // One training step: count up on taken, down on not-taken, never wrap.
    function automatic logic [SAT_MAX_W-1:0] sat_next(
        input logic [SAT_MAX_W-1:0] cnt,
        input logic [SAT_MAX_W-1:0] cnt_max,
        input logic                 taken
    );
        logic [SAT_MAX_W-1:0] nxt;
        nxt = cnt;
        if (taken && (cnt < cnt_max)) begin
            nxt = cnt + 1'b1;
        end else if (!taken && (cnt != '0)) begin
            nxt = cnt - 1'b1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/gshare_pred_table_if.sv
// Fetch/execute side bundle of the direction predictor.
//
// Handshake: a request (pred_valid or upd_valid) is accepted on a rising
// edge only while ready=1; while ready=0 requests are dropped with no side
// effects. There is no backpressure once ready=1, so one predict and one
// update can be issued every cycle. rsp_valid is a single-cycle pulse one
// cycle after an accepted predict; rsp_taken/rsp_cnt/rsp_idx hold otherwise.
interface gshare_pred_table_if #(
    parameter int IDX_W = 7,
    parameter int CNT_W = 2
);
    logic             ready;
    logic             pred_valid;
    logic [IDX_W-1:0] pred_pc;
    logic             rsp_valid;
    logic             rsp_taken;
    logic [CNT_W-1:0] rsp_cnt;
    logic [IDX_W-1:0] rsp_idx;
    logic             upd_valid;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_taken;

    modport master (
        input  ready, rsp_valid, rsp_taken, rsp_cnt, rsp_idx,
        output pred_valid, pred_pc, upd_valid, upd_idx, upd_taken
    );

    modport slave (
        output ready, rsp_valid, rsp_taken, rsp_cnt, rsp_idx,
        input  pred_valid, pred_pc, upd_valid, upd_idx, upd_taken
    );
endinterface

// File: rtl/gshare_pred_table_sat_cnt.sv
// Combinational saturating counter step used on the training path.
module gshare_pred_table_sat_cnt
    import gshare_pred_table_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic [CNT_W-1:0] cnt,
    input  logic             taken,
    output logic [CNT_W-1:0] cnt_nxt
);
    localparam logic [SAT_MAX_W-1:0] CNT_MAX = SAT_MAX_W'((1 << CNT_W) - 1);

    assign cnt_nxt = CNT_W'(sat_next(SAT_MAX_W'(cnt), CNT_MAX, taken));
endmodule

// File: rtl/gshare_pred_table.sv
// Branch-direction predictor: table of saturating counters indexed by PC,
// optionally XORed with a global history register. The table is cleared by
// an init sweep after reset; predictions return one cycle after the request.
module gshare_pred_table
    import gshare_pred_table_pkg::*;
#(
    parameter int IDX_W    = 7,
    parameter int CNT_W    = 2,
    parameter int HIST_W   = 4,
    parameter int GSHARE   = 1,
    parameter int INIT_CNT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    gshare_pred_table_if.slave   bus,
    output logic [HIST_W-1:0]    ghr,
    output state_t               state
);
    localparam int DEPTH = 1 << IDX_W;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  init_ptr_q, init_ptr_d;
    logic [CNT_W-1:0]  tbl [DEPTH];
    logic [HIST_W-1:0] ghr_q, ghr_shift;
    logic              run, pred_fire, upd_fire;
    logic [IDX_W-1:0]  pred_idx;
    logic [CNT_W-1:0]  upd_cur, upd_nxt, pred_cnt;
    logic              rsp_valid_q, rsp_taken_q;
    logic [CNT_W-1:0]  rsp_cnt_q;
    logic [IDX_W-1:0]  rsp_idx_q;

    assign run       = (state_q == ST_RUN);
    assign pred_fire = bus.pred_valid && run;
    assign upd_fire  = bus.upd_valid && run;

    // History is zero-extended to the index width before hashing.
    if (GSHARE != 0) begin : g_gshare
        assign pred_idx = bus.pred_pc ^ IDX_W'(ghr_q);
    end else begin : g_bimodal
        assign pred_idx = bus.pred_pc;
    end

    if (HIST_W == 1) begin : g_hist1
        assign ghr_shift = bus.upd_taken;
    end else begin : g_histn
        assign ghr_shift = {ghr_q[HIST_W-2:0], bus.upd_taken};
    end

    assign upd_cur = tbl[bus.upd_idx];

    gshare_pred_table_sat_cnt #(.CNT_W(CNT_W)) u_sat_cnt (
        .cnt     (upd_cur),
        .taken   (bus.upd_taken),
        .cnt_nxt (upd_nxt)
    );

    // Read the predicted counter, forwarding a same-cycle update to the same entry.
    always_comb begin
        pred_cnt = tbl[pred_idx];
        if (upd_fire && (bus.upd_idx == pred_idx)) begin
            pred_cnt = upd_nxt;
        end
    end

    // FSM state and sweep pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_INIT;
            init_ptr_q <= '0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
        end
    end

    // Sweep every entry once, leave INIT after the last one is written.
    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        case (state_q)
            ST_INIT: begin
                init_ptr_d = init_ptr_q + 1'b1;
                if (init_ptr_q == '1) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
            end
        endcase
    end

    // Counter storage: no reset, the sweep gives it a defined value.
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            tbl[init_ptr_q] <= CNT_W'(INIT_CNT);
        end else if (upd_fire) begin
            tbl[bus.upd_idx] <= upd_nxt;
        end
    end

    // Global history shifts in each resolved direction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ghr_q <= '0;
        end else if (upd_fire) begin
            ghr_q <= ghr_shift;
        end
    end

    // Registered response; data holds when no predict is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid_q <= 1'b0;
            rsp_taken_q <= 1'b0;
            rsp_cnt_q   <= '0;
            rsp_idx_q   <= '0;
        end else begin
            rsp_valid_q <= pred_fire;
            if (pred_fire) begin
                rsp_taken_q <= pred_cnt[CNT_W-1];
                rsp_cnt_q   <= pred_cnt;
                rsp_idx_q   <= pred_idx;
            end
        end
    end

    assign bus.ready     = run;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_taken = rsp_taken_q;
    assign bus.rsp_cnt   = rsp_cnt_q;
    assign bus.rsp_idx   = rsp_idx_q;
    assign ghr           = ghr_q;
    assign state         = state_q;
endmodule

// File: tb/tb_gshare_pred_table.sv
// Bench for gshare_pred_table: a bimodal and a gshare instance receive the
// same stimulus; a reference model predicts each response into a queue and a
// negedge monitor pops and compares every response the DUTs produce.
module tb_gshare_pred_table;
    import gshare_pred_table_pkg::*;

    localparam int IDX_W    = 7;
    localparam int CNT_W    = 2;
    localparam int HIST_W   = 4;
    localparam int INIT_CNT = int'(CNT_WNT);
    localparam int DEPTH    = 1 << IDX_W;
    localparam int RSP_W    = 1 + CNT_W + IDX_W;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    gshare_pred_table_if #(.IDX_W(IDX_W), .CNT_W(CNT_W)) bus0 ();
    gshare_pred_table_if #(.IDX_W(IDX_W), .CNT_W(CNT_W)) bus1 ();
    logic [HIST_W-1:0] ghr0, ghr1;
    state_t            state0, state1;

    gshare_pred_table #(.IDX_W(IDX_W), .CNT_W(CNT_W), .HIST_W(HIST_W), .GSHARE(0), .INIT_CNT(INIT_CNT))
        dut0 (.clk(clk), .reset(reset), .bus(bus0), .ghr(ghr0), .state(state0));
    gshare_pred_table #(.IDX_W(IDX_W), .CNT_W(CNT_W), .HIST_W(HIST_W), .GSHARE(1), .INIT_CNT(INIT_CNT))
        dut1 (.clk(clk), .reset(reset), .bus(bus1), .ghr(ghr1), .state(state1));

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    int                mdl0 [DEPTH];
    int                mdl1 [DEPTH];
    logic [HIST_W-1:0] m_ghr0, m_ghr1;
    logic              m_ready;
    logic [RSP_W-1:0]  exp_q0 [$];
    logic [RSP_W-1:0]  exp_q1 [$];
    logic [RSP_W-1:0]  last0 = '0;
    logic [RSP_W-1:0]  last1 = '0;

    function automatic int sat_model(input int c, input logic t);
        if (t) return (c == int'(CNT_ST)) ? c : c + 1;
        return (c == int'(CNT_SNT)) ? c : c - 1;
    endfunction

    function automatic logic [RSP_W-1:0] pack(input int c, input logic [IDX_W-1:0] idx);
        logic [CNT_W-1:0] c2;
        c2 = CNT_W'(c);
        return {c2[CNT_W-1], c2, idx};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            mdl0[i] = INIT_CNT;
            mdl1[i] = INIT_CNT;
        end
        m_ghr0  = '0;
        m_ghr1  = '0;
        m_ready = 1'b0;
        exp_q0.delete();
        exp_q1.delete();
        last0 = '0;
        last1 = '0;
    endtask

    task automatic clear_inputs();
        bus0.pred_valid = 1'b0; bus0.pred_pc = '0;
        bus0.upd_valid  = 1'b0; bus0.upd_idx = '0; bus0.upd_taken = 1'b0;
        bus1.pred_valid = 1'b0; bus1.pred_pc = '0;
        bus1.upd_valid  = 1'b0; bus1.upd_idx = '0; bus1.upd_taken = 1'b0;
    endtask

    task automatic pull_reset();
        reset = 1'b0;
        clear_inputs();
        model_reset();
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic pv, input logic [IDX_W-1:0] pc,
                         input logic uv, input logic [IDX_W-1:0] uidx, input logic ut);
        logic [IDX_W-1:0] idx0, idx1;
        @(negedge clk);
        check("ghr0", 32'(ghr0), 32'(m_ghr0));
        check("ghr1", 32'(ghr1), 32'(m_ghr1));
        bus0.pred_valid = pv; bus0.pred_pc = pc;
        bus0.upd_valid  = uv; bus0.upd_idx = uidx; bus0.upd_taken = ut;
        bus1.pred_valid = pv; bus1.pred_pc = pc;
        bus1.upd_valid  = uv; bus1.upd_idx = uidx; bus1.upd_taken = ut;
        if (m_ready) begin
            idx0 = pc;
            idx1 = pc ^ IDX_W'(m_ghr1);
            if (uv) begin
                mdl0[uidx] = sat_model(mdl0[uidx], ut);
                mdl1[uidx] = sat_model(mdl1[uidx], ut);
                m_ghr0 = {m_ghr0[HIST_W-2:0], ut};
                m_ghr1 = {m_ghr1[HIST_W-2:0], ut};
            end
            if (pv) begin
                exp_q0.push_back(pack(mdl0[idx0], idx0));
                exp_q1.push_back(pack(mdl1[idx1], idx1));
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (bus0.rsp_valid) begin
            if (exp_q0.size() == 0) check("rsp0_unexpected", 32'(1), 32'(0));
            else begin
                last0 = exp_q0.pop_front();
                check("rsp0", 32'({bus0.rsp_taken, bus0.rsp_cnt, bus0.rsp_idx}), 32'(last0));
            end
        end else begin
            check("hold0", 32'({bus0.rsp_taken, bus0.rsp_cnt, bus0.rsp_idx}), 32'(last0));
        end
        if (bus1.rsp_valid) begin
            if (exp_q1.size() == 0) check("rsp1_unexpected", 32'(1), 32'(0));
            else begin
                last1 = exp_q1.pop_front();
                check("rsp1", 32'({bus1.rsp_taken, bus1.rsp_cnt, bus1.rsp_idx}), 32'(last1));
            end
        end else begin
            check("hold1", 32'({bus1.rsp_taken, bus1.rsp_cnt, bus1.rsp_idx}), 32'(last1));
        end
    end

    // Release reset, measure the sweep, optionally pulse requests during it.
    task automatic sweep(input string tag, input logic pulse);
        int n;
        @(negedge clk);
        reset = 1'b1;
        check({tag, "_ready_low"}, 32'(bus0.ready), 32'(0));
        n = 0;
        while (n < 300) begin
            @(posedge clk);
            #1;
            n++;
            if (bus0.ready) break;
            if (pulse && n == 20) begin
                bus0.pred_valid = 1'b1; bus0.pred_pc = 7'd2;
                bus0.upd_valid  = 1'b1; bus0.upd_idx = 7'd2; bus0.upd_taken = 1'b1;
                bus1.pred_valid = 1'b1; bus1.pred_pc = 7'd2;
                bus1.upd_valid  = 1'b1; bus1.upd_idx = 7'd2; bus1.upd_taken = 1'b1;
            end
            if (pulse && n == 23) clear_inputs();
        end
        check({tag, "_sweep_len"}, 32'(n), 32'(DEPTH));
        check({tag, "_ready1"}, 32'(bus1.ready), 32'(1));
        check({tag, "_state"}, 32'(state0), 32'(ST_RUN));
        check({tag, "_ghr"}, 32'(ghr1), 32'(0));
        m_ready = 1'b1;
    endtask

    // Issue one predict and look at the response directly after the edge.
    task automatic predict_look(input string tag, input logic [IDX_W-1:0] pc, input logic dut_sel,
                                input int exp_cnt, input logic [IDX_W-1:0] exp_idx);
        drive(1'b1, pc, 1'b0, '0, 1'b0);
        @(posedge clk);
        #1;
        if (dut_sel) begin
            check({tag, "_valid"}, 32'(bus1.rsp_valid), 32'(1));
            check({tag, "_cnt"},   32'(bus1.rsp_cnt),   32'(exp_cnt));
            check({tag, "_taken"}, 32'(bus1.rsp_taken), 32'(exp_cnt >= 2));
            check({tag, "_idx"},   32'(bus1.rsp_idx),   32'(exp_idx));
        end else begin
            check({tag, "_valid"}, 32'(bus0.rsp_valid), 32'(1));
            check({tag, "_cnt"},   32'(bus0.rsp_cnt),   32'(exp_cnt));
            check({tag, "_taken"}, 32'(bus0.rsp_taken), 32'(exp_cnt >= 2));
            check({tag, "_idx"},   32'(bus0.rsp_idx),   32'(exp_idx));
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        clear_inputs();
        model_reset();
        #2;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready",  32'(bus0.ready),     32'(0));
        check("rst_valid",  32'(bus0.rsp_valid), 32'(0));
        check("rst_state0", 32'(state0),         32'(ST_INIT));
        check("rst_state1", 32'(state1),         32'(ST_INIT));
        check("rst_ghr",    32'(ghr1),           32'(0));

        // 1: sweep length and a first prediction of the init value
        sweep("t1", 1'b0);
        predict_look("t1", 7'd2, 1'b0, int'(CNT_WNT), 7'd2);

        // 2: train towards taken, saturating at the top
        repeat (3) drive(1'b0, '0, 1'b1, 7'd2, 1'b1);
        predict_look("t2", 7'd2, 1'b0, int'(CNT_ST), 7'd2);

        // 3: train towards not-taken, saturating at zero
        repeat (3) drive(1'b0, '0, 1'b1, 7'd9, 1'b0);
        predict_look("t3", 7'd9, 1'b0, int'(CNT_SNT), 7'd9);

        // 4: same-cycle predict and update on one entry returns the trained value
        drive(1'b1, 7'd5, 1'b1, 7'd5, 1'b1);
        @(posedge clk);
        #1;
        check("t4_cnt",   32'(bus0.rsp_cnt),   32'(CNT_WT));
        check("t4_taken", 32'(bus0.rsp_taken), 32'(1));
        // same cycle, different entries stay independent
        drive(1'b1, 7'd6, 1'b1, 7'd7, 1'b1);
        @(posedge clk);
        #1;
        check("t4b_cnt", 32'(bus0.rsp_cnt), 32'(CNT_WNT));
        idle(1);

        // 5: history hashing on the gshare instance
        drive(1'b0, '0, 1'b1, 7'h40, 1'b1);
        drive(1'b0, '0, 1'b1, 7'h40, 1'b1);
        drive(1'b0, '0, 1'b1, 7'h40, 1'b0);
        drive(1'b0, '0, 1'b1, 7'h40, 1'b1);
        idle(1);
        check("t5_ghr", 32'(ghr1), 32'(4'b1101));
        predict_look("t5", 7'h02, 1'b1, int'(CNT_WNT), 7'h0F);
        idle(1);

        // random back-to-back traffic on a small index range to force collisions
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), 7'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 7'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end
        idle(2);
        check("drain0", 32'(exp_q0.size()), 32'(0));
        check("drain1", 32'(exp_q1.size()), 32'(0));

        // 6: reset mid-run clears outputs at once
        drive(1'b1, 7'd3, 1'b0, '0, 1'b0);
        @(posedge clk);
        #1;
        check("t6_pre_valid", 32'(bus0.rsp_valid), 32'(1));
        pull_reset();
        #1;
        check("t6_run_ready", 32'(bus0.ready),     32'(0));
        check("t6_run_valid", 32'(bus0.rsp_valid), 32'(0));
        check("t6_run_cnt",   32'(bus0.rsp_cnt),   32'(0));
        check("t6_run_state", 32'(state1),         32'(ST_INIT));
        @(negedge clk);
        reset = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("t6_mid_state", 32'(state0), 32'(ST_INIT));
        pull_reset();
        #1;
        check("t6_mid_ready", 32'(bus0.ready),     32'(0));
        check("t6_mid_valid", 32'(bus1.rsp_valid), 32'(0));
        sweep("t6", 1'b1);
        predict_look("t6", 7'd2, 1'b0, int'(CNT_WNT), 7'd2);
        predict_look("t6g", 7'd2, 1'b1, int'(CNT_WNT), 7'd2);
        idle(2);
        check("final_drain0", 32'(exp_q0.size()), 32'(0));
        check("final_drain1", 32'(exp_q1.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
